// File: rtl/addsub_result_stage.sv
// Registered result stage for the DSP add/sub unit: derives condition flags from the
// operands and sum, and hands entries downstream through a 2-entry valid/ready skid buffer.
module addsub_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_lt,
    output logic             out_ltu
);

    localparam int M = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic             lt;
        logic             ltu;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state_q;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     entry_d;
    logic [WIDTH-1:0] bx;
    logic       accept;
    logic       pop;

    // The DSP inverts B for subtraction, so flags are derived against the inverted operand.
    always_comb begin
        bx            = in_sub ? ~in_b : in_b;
        entry_d.sum   = in_sum;
        entry_d.zero  = ~|in_sum;
        entry_d.neg   = in_sum[M];
        entry_d.carry = (in_a[M] & bx[M]) | ((in_a[M] | bx[M]) & ~in_sum[M]);
        entry_d.ovf   = (in_a[M] == bx[M]) & (in_sum[M] != in_a[M]);
        entry_d.lt    = in_sub & (in_sum[M] ^ entry_d.ovf);
        entry_d.ltu   = in_sub & ~entry_d.carry;
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= BUSY;
                        main_q  <= entry_d;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        main_q <= entry_d;
                    end else if (accept) begin
                        state_q <= FULL;
                        skid_q  <= entry_d;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q <= BUSY;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_sum   = main_q.sum;
    assign out_zero  = main_q.zero;
    assign out_neg   = main_q.neg;
    assign out_carry = main_q.carry;
    assign out_ovf   = main_q.ovf;
    assign out_lt    = main_q.lt;
    assign out_ltu   = main_q.ltu;

endmodule
